// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared constants and FSM state type for the channel sequencer
package jt6295_pkg;
  localparam int JT6295_CH = 4;
  localparam int JT6295_AW = 18;
  localparam int JT6295_PW = JT6295_AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;
endpackage

// File: rtl/jt6295_chreg.sv
// jt6295_chreg: four-voice register file with start-edge capture, stop override and slot-indexed advance
module jt6295_chreg
  import jt6295_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [JT6295_CH-1:0] start,
  input  logic [JT6295_CH-1:0] stop,
  input  logic [JT6295_AW-1:0] start_addr,
  input  logic [JT6295_AW-1:0] stop_addr,
  input  logic [3:0]           att,
  input  logic [1:0]           sel,
  input  logic                 adv,
  output logic [JT6295_PW-1:0] rd_ptr,
  output logic [3:0]           rd_att,
  output logic [JT6295_CH-1:0] busy
);
  logic [JT6295_PW-1:0] ptr [JT6295_CH];
  logic [JT6295_AW-1:0] fin [JT6295_CH];
  logic [3:0]           atv [JT6295_CH];
  logic [JT6295_CH-1:0] start_q, edge_q;
  logic                 last;
  assign rd_ptr = ptr[sel];
  assign rd_att = atv[sel];
  assign last   = rd_ptr[0] && rd_ptr[JT6295_PW-1:1] == fin[sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      edge_q  <= '0;
      busy    <= '0;
      for (int i = 0; i < JT6295_CH; i++) begin
        ptr[i] <= '0;
        fin[i] <= '0;
        atv[i] <= '0;
      end
    end else begin
      start_q <= start;
      edge_q  <= start & ~start_q;
      for (int i = 0; i < JT6295_CH; i++) begin
        if (edge_q[i] && !busy[i] && !stop[i]) begin
          ptr[i] <= {start_addr, 1'b0};
          fin[i] <= stop_addr;
          atv[i] <= att;
        end else if (adv && sel == 2'(i) && busy[i] && !stop[i] && !last)
          ptr[i] <= ptr[i] + 1'b1;
        busy[i] <= stop[i] ? 1'b0 :
                   edge_q[i] && !busy[i] ? 1'b1 :
                   adv && sel == 2'(i) && last ? 1'b0 : busy[i];
      end
    end
  end
endmodule

// File: rtl/jt6295_chseq.sv
// jt6295_chseq: round-robin sample ROM fetch sequencer emitting one ADPCM nibble per active voice slot
module jt6295_chseq
  import jt6295_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic [JT6295_AW-1:0] start_addr,
  input  logic [JT6295_AW-1:0] stop_addr,
  input  logic [3:0]           att,
  input  logic [3:0]           start,
  input  logic [3:0]           stop,
  output logic [3:0]           busy,
  output logic [JT6295_AW-1:0] rom_addr,
  output logic                 rom_cs,
  input  logic [7:0]           rom_data,
  input  logic                 rom_ok,
  output logic [3:0]           nib,
  output logic [1:0]           nib_ch,
  output logic [3:0]           nib_att,
  output logic                 nib_valid
);
  state_t               state, nxt;
  logic [1:0]           slot;
  logic                 pend, armed, go, got, fetch;
  logic [JT6295_PW-1:0] ptr;
  logic [3:0]           vatt;
  jt6295_chreg u_chreg (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .att        (att),
    .sel        (slot),
    .adv        (state == OUT),
    .rd_ptr     (ptr),
    .rd_att     (vatt),
    .busy       (busy)
  );
  assign go    = cen || pend;
  assign fetch = state == IDLE && go && busy[slot];
  assign got   = state == REQ && armed && rom_ok;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (fetch ? REQ : IDLE) :
          state == REQ  ? (got ? OUT : REQ) : IDLE;
  always_comb begin
    rom_cs    = state == REQ;
    nib_valid = state == OUT && busy[slot] && !stop[slot];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      pend     <= 1'b0;
      armed    <= 1'b0;
      rom_addr <= '0;
      nib      <= '0;
      nib_ch   <= '0;
      nib_att  <= '0;
    end else begin
      armed <= state == REQ;
      pend  <= state == IDLE ? 1'b0 : pend || cen;
      if ((state == IDLE && go && !busy[slot]) || state == OUT)
        slot <= slot + 1'b1;
      if (fetch)
        rom_addr <= ptr[JT6295_PW-1:1];
      if (got) begin
        nib     <= ptr[0] ? rom_data[3:0] : rom_data[7:4];
        nib_ch  <= slot;
        nib_att <= vatt;
      end
    end
  end
endmodule

// File: tb/tb_jt6295_chseq.sv
// tb_jt6295_chseq: directed scenario tests for the channel sequencer with a small ROM model
module tb_jt6295_chseq;
  logic        clk = 0, rst = 1, cen_run = 0, cen_man = 0, ok_en = 1;
  logic [17:0] start_addr = 0, stop_addr = 0, rom_addr;
  logic [3:0]  att = 0, start = 0, stop = 0, busy, nib, nib_att;
  logic [1:0]  nib_ch, ccnt = 0;
  logic [7:0]  rom_data;
  logic        rom_cs, nib_valid, cen, rom_ok, cs_q = 0;
  logic [9:0]  nq [$];
  logic [17:0] aq [$];
  int          errors = 0, checks = 0;

  jt6295_chseq dut (
    .clk(clk), .rst(rst), .cen(cen), .start_addr(start_addr), .stop_addr(stop_addr),
    .att(att), .start(start), .stop(stop), .busy(busy), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .nib(nib), .nib_ch(nib_ch),
    .nib_att(nib_att), .nib_valid(nib_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ccnt <= ccnt + 1'b1;
  assign cen    = (cen_run && ccnt == 2'd0) || cen_man;
  assign rom_ok = ok_en;

  always_comb
    case (rom_addr)
      18'h00100: rom_data = 8'hA5;
      18'h00101: rom_data = 8'h3C;
      18'h00200: rom_data = 8'h56;
      18'h00300: rom_data = 8'h78;
      18'h00400: rom_data = 8'h9A;
      18'h00500: rom_data = 8'hBC;
      18'h3FFFF: rom_data = 8'h12;
      18'h00000: rom_data = 8'h34;
      default:   rom_data = 8'h00;
    endcase

  always @(negedge clk) begin
    if (!rst && nib_valid) nq.push_back({nib_ch, nib_att, nib});
    if (!rst && rom_cs && !cs_q) aq.push_back(rom_addr);
    cs_q <= rom_cs;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cen_run = 0; cen_man = 0; start = 0; stop = 0; ok_en = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    nq.delete();
    aq.delete();
  endtask

  task automatic do_start(input int c, input logic [17:0] sa, input logic [17:0] ea, input logic [3:0] a);
    start_addr = sa; stop_addr = ea; att = a;
    start[c] = 1'b1;
    repeat (3) tick();
    start[c] = 1'b0;
    tick();
  endtask

  task automatic run(input int n);
    cen_run = 1;
    repeat (n) tick();
    cen_run = 0;
    repeat (8) tick();
  endtask

  task automatic pulse();
    cen_man = 1;
    tick();
    cen_man = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    start = 4'hF;
    repeat (3) tick();
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    checks++; if (rom_addr !== 18'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    checks++; if (nib !== 4'h0) begin errors++; $display("FAIL reset_nib: got %h want 0", nib); end
    checks++; if (nib_ch !== 2'd0) begin errors++; $display("FAIL reset_nib_ch: got %0d want 0", nib_ch); end
    checks++; if (nib_att !== 4'h0) begin errors++; $display("FAIL reset_nib_att: got %h want 0", nib_att); end
    checks++; if (nib_valid !== 1'b0) begin errors++; $display("FAIL reset_nib_valid: got %b want 0", nib_valid); end
    start = 0;
  endtask

  task automatic test_basic();
    logic [9:0]  eb [4];
    logic [17:0] ea [4];
    eb = '{{2'd0, 4'd5, 4'hA}, {2'd0, 4'd5, 4'h5}, {2'd0, 4'd5, 4'h3}, {2'd0, 4'd5, 4'hC}};
    ea = '{18'h00100, 18'h00100, 18'h00101, 18'h00101};
    do_reset();
    start_addr = 18'h00100; stop_addr = 18'h00101; att = 4'd5;
    start[0] = 1;
    tick();
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL start_busy_early: got %b want 0", busy[0]); end
    tick();
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL start_busy_rise: got %b want 1", busy[0]); end
    start[0] = 0;
    run(80);
    checks++; if (nq.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", nq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nq.size() <= i || nq[i] !== eb[i]) begin errors++; $display("FAIL basic_nib[%0d]: got %h want %h", i, nq.size() > i ? nq[i] : 10'h3FF, eb[i]); end
      checks++;
      if (aq.size() <= i || aq[i] !== ea[i]) begin errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, aq.size() > i ? aq[i] : 18'h3FFFF, ea[i]); end
    end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL basic_busy_end: got %h want 0", busy); end
  endtask

  task automatic test_interleave();
    logic [9:0]  eb [4];
    logic [17:0] ea [4];
    eb = '{{2'd0, 4'd3, 4'h5}, {2'd2, 4'd9, 4'h7}, {2'd0, 4'd3, 4'h6}, {2'd2, 4'd9, 4'h8}};
    ea = '{18'h00200, 18'h00300, 18'h00200, 18'h00300};
    do_reset();
    do_start(0, 18'h00200, 18'h00200, 4'd3);
    do_start(2, 18'h00300, 18'h00300, 4'd9);
    nq.delete(); aq.delete();
    run(48);
    checks++; if (nq.size() != 4) begin errors++; $display("FAIL inter_count: got %0d want 4", nq.size()); end
    checks++; if (aq.size() != 4) begin errors++; $display("FAIL inter_fetches: got %0d want 4", aq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nq.size() <= i || nq[i] !== eb[i]) begin errors++; $display("FAIL inter_nib[%0d]: got %h want %h", i, nq.size() > i ? nq[i] : 10'h3FF, eb[i]); end
      checks++;
      if (aq.size() <= i || aq[i] !== ea[i]) begin errors++; $display("FAIL inter_addr[%0d]: got %h want %h", i, aq.size() > i ? aq[i] : 18'h3FFFF, ea[i]); end
    end
  endtask

  task automatic test_stop();
    int n;
    do_reset();
    do_start(1, 18'h00400, 18'h00400, 4'd2);
    nq.delete(); aq.delete();
    cen_run = 1;
    for (n = 0; n < 40 && rom_cs !== 1'b1; n++) tick();
    checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL stop_wait_req: timeout, rom_cs %b want 1", rom_cs); end
    stop[1] = 1;
    tick();
    stop[1] = 0;
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy[1]); end
    checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL stop_handshake_held: got %b want 1", rom_cs); end
    repeat (20) tick();
    cen_run = 0;
    repeat (8) tick();
    checks++; if (nq.size() != 0) begin errors++; $display("FAIL stop_no_nib: got %0d nibbles want 0", nq.size()); end
    checks++; if (aq.size() != 1) begin errors++; $display("FAIL stop_fetches: got %0d want 1", aq.size()); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL stop_cs_released: got %b want 0", rom_cs); end
    start[1] = 1; stop[1] = 1;
    repeat (3) tick();
    start[1] = 0; stop[1] = 0;
    repeat (2) tick();
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL start_stop_same: got %h want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [9:0]  eb [4];
    logic [17:0] ea [4];
    eb = '{{2'd0, 4'd1, 4'h1}, {2'd0, 4'd1, 4'h2}, {2'd0, 4'd1, 4'h3}, {2'd0, 4'd1, 4'h4}};
    ea = '{18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h00000};
    do_reset();
    do_start(0, 18'h3FFFF, 18'h00000, 4'd1);
    nq.delete(); aq.delete();
    run(80);
    checks++; if (nq.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", nq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nq.size() <= i || nq[i] !== eb[i]) begin errors++; $display("FAIL wrap_nib[%0d]: got %h want %h", i, nq.size() > i ? nq[i] : 10'h3FF, eb[i]); end
      checks++;
      if (aq.size() <= i || aq[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, aq.size() > i ? aq[i] : 18'h3FFFF, ea[i]); end
    end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL wrap_busy_end: got %h want 0", busy); end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    do_start(0, 18'h00500, 18'h00500, 4'd7);
    nq.delete(); aq.delete();
    ok_en = 0;
    pulse();
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00500) begin errors++; $display("FAIL stall_req: got cs %b addr %h want 1 00500", rom_cs, rom_addr); end
    for (int i = 0; i < 9; i++) begin
      cen_man = (i == 1 || i == 4);
      tick();
      cen_man = 0;
      checks++;
      if (rom_cs !== 1'b1 || rom_addr !== 18'h00500) begin errors++; $display("FAIL stall_hold[%0d]: got cs %b addr %h want 1 00500", i, rom_cs, rom_addr); end
    end
    ok_en = 1;
    for (n = 0; n < 20 && nq.size() == 0; n++) tick();
    repeat (4) tick();
    checks++; if (nq.size() != 1) begin errors++; $display("FAIL stall_count: got %0d want 1", nq.size()); end
    checks++; if (nq.size() < 1 || nq[0] !== {2'd0, 4'd7, 4'hB}) begin errors++; $display("FAIL stall_nib: got %h want %h", nq.size() > 0 ? nq[0] : 10'h3FF, {2'd0, 4'd7, 4'hB}); end
    pulse(); repeat (3) tick();
    pulse(); repeat (3) tick();
    checks++; if (nq.size() != 1) begin errors++; $display("FAIL stall_dropped_cen: got %0d nibbles want 1", nq.size()); end
    pulse();
    checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL lat_cs_t1: got %b want 1", rom_cs); end
    tick();
    checks++; if (nib_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_t2: got %b want 0", nib_valid); end
    tick();
    checks++; if (nib_valid !== 1'b1 || nib !== 4'hC || nib_ch !== 2'd0 || nib_att !== 4'd7) begin errors++; $display("FAIL lat_out_t3: got v%b n%h c%0d a%h want v1 nC c0 a7", nib_valid, nib, nib_ch, nib_att); end
    tick();
    checks++; if (busy[0] !== 1'b0 || nib_valid !== 1'b0) begin errors++; $display("FAIL lat_t4: got busy %b valid %b want 0 0", busy[0], nib_valid); end
  endtask

  task automatic test_retrigger();
    int n;
    logic [9:0] eb [4];
    eb = '{{2'd3, 4'd4, 4'hA}, {2'd3, 4'd4, 4'h5}, {2'd3, 4'd4, 4'h3}, {2'd3, 4'd4, 4'hC}};
    do_reset();
    do_start(3, 18'h00100, 18'h00101, 4'd4);
    do_start(3, 18'h00200, 18'h00200, 4'd9);
    nq.delete(); aq.delete();
    run(80);
    checks++; if (nq.size() != 4) begin errors++; $display("FAIL retrig_count: got %0d want 4", nq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nq.size() <= i || nq[i] !== eb[i]) begin errors++; $display("FAIL retrig_nib[%0d]: got %h want %h", i, nq.size() > i ? nq[i] : 10'h3FF, eb[i]); end
    end
    do_start(3, 18'h00100, 18'h00101, 4'd4);
    cen_run = 1;
    for (n = 0; n < 40 && rom_cs !== 1'b1; n++) tick();
    checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL rst_wait_req: timeout, rom_cs %b want 1", rom_cs); end
    rst = 1;
    tick();
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rst_mid_cs: got %b want 0", rom_cs); end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL rst_mid_busy: got %h want 0", busy); end
    checks++; if (rom_addr !== 18'h0) begin errors++; $display("FAIL rst_mid_addr: got %h want 0", rom_addr); end
    checks++; if (nib_valid !== 1'b0 || nib !== 4'h0 || nib_ch !== 2'd0 || nib_att !== 4'h0) begin errors++; $display("FAIL rst_mid_nib: got v%b n%h c%0d a%h want all 0", nib_valid, nib, nib_ch, nib_att); end
    cen_run = 0;
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_stop();
    test_wrap();
    test_stall();
    test_retrigger();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jt6295_chseq.md
# jt6295_chseq

Per-channel sample address sequencer sitting directly downstream of the JT6295 phrase-table controller. It takes the resolved start/stop byte addresses, attenuation and start/stop strobes for four voices. It then time-multiplexes the voices round-robin, fetches ADPCM bytes from sample ROM, and emits one 4-bit ADPCM nibble per active voice per slot to the decoder. It also reports per-voice `busy` back upstream.

## Interface
- Parameters: none. Voice count is fixed at 4 and byte address width at 18.
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `cen` in 1 — slot enable, one pulse per voice slot.
- `start_addr` in 18 — first byte of the phrase; valid while any `start` bit rises.
- `stop_addr` in 18 — last byte of the phrase (inclusive).
- `att` in 4 — attenuation captured with the phrase.
- `start` in 4 — per-voice start request; level signal, rising edge acts.
- `stop` in 4 — per-voice stop request; level signal, high forces idle.
- `busy` out 4 — voice playing.
- `rom_addr` out 18 — sample ROM byte address.
- `rom_cs` out 1 — ROM read request.
- `rom_data` in 8 — ROM read data.
- `rom_ok` in 1 — ROM data valid for the current `rom_addr`.
- `nib` out 4 — ADPCM nibble.
- `nib_ch` out 2 — voice owning `nib`.
- `nib_att` out 4 — attenuation of `nib_ch`.
- `nib_valid` out 1 — one-cycle strobe marking `nib`/`nib_ch`/`nib_att` new.

## Operation
- Per-voice state: 19-bit nibble pointer `ptr` = {byte address, half}, 18-bit `end`, 4-bit `att`, and a `busy` bit.
- **Start:** on a 0→1 edge of `start[c]` with `busy[c]`=0, the block loads `ptr`={start_addr,0}, `end`=stop_addr, `att`=att, and sets `busy[c]`=1.
  - A start edge on an already-busy voice is ignored.
  - Each start bit has its own edge detector, registered every clk.
- **Stop:** `stop[c]`=1 clears `busy[c]` on the next clk. Stop beats a same-cycle start edge.
- **Slot pointer:** `slot` is 2 bits, counts 0,1,2,3,0…, and advances on each accepted `cen`.
- **FSM states:** IDLE, REQ, OUT.
  - IDLE: on `cen`, if `busy[slot]`=1, drive `rom_addr`=ptr[18:1] and `rom_cs`=1, then go to REQ. If `busy[slot]`=0, stay in IDLE; no ROM access and no `nib_valid`.
  - REQ: `rom_ok` is ignored in the first REQ cycle (stale-ok guard). From the second cycle on, `rom_ok`=1 latches `rom_data`, drops `rom_cs`, and moves to OUT.
  - OUT: emit `nib` = rom_data[7:4] if ptr[0]=0, else rom_data[3:0], with `nib_valid`=1, `nib_ch`=slot, `nib_att`=att[slot]. Then:
    - if ptr[0]=1 and ptr[18:1]==end, clear `busy[slot]`;
    - otherwise `ptr`←ptr+1, wrapping modulo 2^19.
    - Return to IDLE.
- **End before start:** stop_addr < start_addr plays through the wrap to 0 until it matches.
- **Stop mid-fetch:** `stop[slot]` asserted while in REQ or OUT completes the ROM handshake but suppresses `nib_valid`. `busy` is cleared.
- **`cen` while not IDLE:** held in a one-deep pending flag and serviced on return to IDLE. A further `cen` while pending is dropped, and `slot` does not advance for it.

## Timing
- Reset values: busy=0, rom_cs=0, rom_addr=0, nib=0, nib_ch=0, nib_att=0, nib_valid=0, slot=0, FSM=IDLE, pending=0, edge detectors=0.
- Reset mid-fetch aborts the fetch immediately, with `rom_cs` low the next cycle.
- `cen` at cycle t means `rom_cs`=1 from t+1. With `rom_ok` high throughout, data is latched at t+2 and `nib_valid`=1 at t+3. Minimum latency is 3 cycles.
- `busy` rises 1 cycle after the start edge is registered, i.e. 2 clk after `start` goes high.
- `busy` falls in the OUT cycle of the final low nibble, visible at t+4.
- `rom_addr` is stable while `rom_cs`=1.

## Structure
- Package `jt6295_pkg` holds:
  - `JT6295_CH`=4 and `JT6295_AW`=18;
  - the FSM state enum {IDLE, REQ, OUT};
  - the nibble-pointer width AW+1.
- One sub-module, `jt6295_chreg`: the 4-entry voice register file (ptr, end, att, busy) with start-edge/stop logic. It has a single read port indexed by `slot` and a single update port from the FSM.

## Test plan
- **Basic playback:** start[0] edge with start_addr=0x00100, stop_addr=0x00101, ROM bytes 0xA5,0x3C, continuous `cen` with rom_ok=1 → voice-0 nibbles A,5,3,C on nib_ch=0 in successive ch-0 slots; busy[0] falls after C.
- **Interleave:** voices 0 and 2 active, 1 and 3 idle → `nib_valid` only in slots 0 and 2; no `rom_cs` in slots 1 and 3.
- **Stop override:** stop[1] asserted while ch1 is in REQ → ROM handshake completes, no `nib_valid`, busy[1]=0 the next cycle. A same-cycle start+stop leaves busy=0.
- **Wrap-around:** start_addr=0x3FFFF, stop_addr=0x00000 → fetch addresses 0x3FFFF then 0x00000; 4 nibbles, then busy clears.
- **ROM stall:** rom_ok held low for 10 cycles with two `cen` pulses arriving meanwhile → first `cen` kept pending and serviced next, second dropped; `rom_addr` stable during the stall.
- **Retrigger ignored:** start edge on busy voice 3 with new addresses → playback continues at old addresses; reset mid-REQ → all outputs return to reset values.
